// File: rtl/bsa_pkg.sv
// Shared definitions for the bit-serial adder: FSM encodings, default width,
// and the counter-width helper.
package bsa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  localparam int DEF_WIDTH = 8;

  // ceil(log2(w)), never less than 1 so the counter always has a bit
  function automatic int cnt_w(input int w);
    int r;
    r = 0;
    for (int i = 0; i < 6; i++)
      if ((1 << r) < w) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Combinational 1-bit full adder; the single primitive the serial datapath reuses.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic sum,
  output logic co
);

  assign sum = a ^ b ^ ci;
  assign co  = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/bit_serial_adder.sv
// WIDTH-bit adder that walks one full_adder_cell LSB-first over WIDTH cycles,
// with valid/ready handshakes on operand and result sides.
module bit_serial_adder
  import bsa_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_sh_a;
  logic [WIDTH-1:0] r_sh_b;
  logic [WIDTH-1:0] r_result;

  logic w_shift;
  logic w_cell_a;
  logic w_cell_b;
  logic w_cell_ci;
  logic w_cell_sum;
  logic w_cell_co;

  // Cell inputs are gated so it only ever sees live operand bits in SHIFT
  assign w_shift   = (r_state == ST_SHIFT);
  assign w_cell_a  = w_shift & r_sh_a[0];
  assign w_cell_b  = w_shift & r_sh_b[0];
  assign w_cell_ci = w_shift & r_carry;

  full_adder_cell u_cell (
    .a   (w_cell_a),
    .b   (w_cell_b),
    .ci  (w_cell_ci),
    .sum (w_cell_sum),
    .co  (w_cell_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_sh_a   <= '0;
      r_sh_b   <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_sh_a   <= a;
            r_sh_b   <= b;
            r_carry  <= cin;
            r_cnt    <= '0;
            r_result <= '0;
            r_state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // Sum bits enter at the MSB so after WIDTH shifts bit 0 lands at [0]
          r_result <= {w_cell_sum, r_result[WIDTH-1:1]};
          r_carry  <= w_cell_co;
          r_sh_a   <= r_sh_a >> 1;
          r_sh_b   <= r_sh_b >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LAST) r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state == ST_SHIFT) || (r_state == ST_DONE);
  assign sum       = r_result;
  assign cout      = r_carry;

endmodule
